// File: rtl/axis_video_pattern_gen.sv
// axis_video_pattern_gen: framed AXI-Stream test-pattern source paced by a programmable frame interval
module axis_video_pattern_gen #(
  parameter int AXIS_DATA_WIDTH = 24,
  parameter int IMG_WIDTH_MAX = 16,
  parameter int IMG_HEIGHT_MAX = 16
) (
  input  logic                       i_axi_clk,
  input  logic                       i_axi_rst,
  input  logic                       i_enable,
  input  logic [IMG_WIDTH_MAX-1:0]   i_width,
  input  logic [IMG_HEIGHT_MAX-1:0]  i_height,
  input  logic [31:0]                i_frame_interval,
  input  logic [1:0]                 i_pattern,
  input  logic [AXIS_DATA_WIDTH-1:0] i_color,
  input  logic                       i_clear_stats,
  output logic                       o_busy,
  output logic [31:0]                o_frame_count,
  output logic                       o_frame_late,
  output logic                       o_axis_out_tuser,
  output logic                       o_axis_out_tvalid,
  input  logic                       i_axis_out_tready,
  output logic                       o_axis_out_tlast,
  output logic [AXIS_DATA_WIDTH-1:0] o_axis_out_tdata
);
  typedef enum logic [1:0] {IDLE, WAIT, ACTIVE} state_t;
  state_t state, state_next;
  logic [31:0] cnt, lim;
  logic [IMG_WIDTH_MAX-1:0] x, w_q;
  logic [IMG_HEIGHT_MAX-1:0] y, h_q;
  logic [1:0] pat_q;
  logic [AXIS_DATA_WIDTH-1:0] color_q, x_d, y_d;
  logic tick, start, accept, eol, last_beat;

  // frame pacing tick and beat bookkeeping; the counter sits at 0 in IDLE so the first tick is immediate
  always_comb begin
    lim = i_frame_interval == 32'd0 ? 32'd1 : i_frame_interval;
    tick = i_enable && state != IDLE && cnt == 32'd0;
    start = state == WAIT && tick && i_width != '0 && i_height != '0;
    accept = o_axis_out_tvalid && i_axis_out_tready;
    eol = x == w_q - 1'b1;
    last_beat = accept && eol && y == h_q - 1'b1;
    x_d = AXIS_DATA_WIDTH'(x);
    y_d = AXIS_DATA_WIDTH'(y);
  end

  // state register
  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) state <= IDLE;
    else state <= state_next;
  end

  // next state: a started frame always runs to its final beat, even if enable drops
  always_comb begin
    state_next = state == IDLE ? (i_enable ? WAIT : IDLE) :
                 state == WAIT ? (!i_enable ? IDLE : start ? ACTIVE : WAIT) :
                 last_beat ? (i_enable ? WAIT : IDLE) : ACTIVE;
  end

  // interval counter, per-frame config latch, pixel position and statistics
  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) begin
      cnt <= '0;
      x <= '0;
      y <= '0;
      w_q <= '0;
      h_q <= '0;
      pat_q <= '0;
      color_q <= '0;
      o_frame_count <= '0;
      o_frame_late <= 1'b0;
    end else begin
      cnt <= state == IDLE ? 32'd0 : !i_enable ? cnt : cnt >= lim - 32'd1 ? 32'd0 : cnt + 32'd1;
      if (start) begin
        w_q <= i_width;
        h_q <= i_height;
        pat_q <= i_pattern;
        color_q <= i_color;
        x <= '0;
        y <= '0;
      end else if (accept) begin
        x <= eol ? '0 : x + 1'b1;
        y <= eol ? y + 1'b1 : y;
      end
      o_frame_count <= i_clear_stats ? 32'd0 : o_frame_count + 32'(last_beat);
      o_frame_late <= !i_clear_stats && (o_frame_late || (tick && state == ACTIVE));
    end
  end

  // stream outputs derive from held state, so they stay stable across stalls
  always_comb begin
    o_busy = state == ACTIVE;
    o_axis_out_tvalid = o_busy;
    o_axis_out_tuser = o_busy && x == '0 && y == '0;
    o_axis_out_tlast = o_busy && eol;
    o_axis_out_tdata = !o_busy ? '0 :
                       pat_q == 2'd0 ? color_q :
                       pat_q == 2'd1 ? x_d :
                       pat_q == 2'd2 ? y_d : {AXIS_DATA_WIDTH{x[3] ^ y[3]}};
  end
endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// tb_axis_video_pattern_gen: scoreboard bench for the video pattern generator
module tb_axis_video_pattern_gen;
  logic clk = 0, rst_n = 0, en = 0, ready = 0, clr = 0, rnd = 0;
  logic [15:0] w = 0, h = 0;
  logic [31:0] ivl = 0;
  logic [1:0] pat = 0;
  logic [23:0] color = 0;
  logic busy, late, tuser, tvalid, tlast;
  logic [31:0] fcount;
  logic [23:0] tdata;
  typedef struct {logic [23:0] d; logic u; logic l;} beat_t;
  beat_t q[$];
  int sof_t[$];
  int checks = 0, errors = 0, cyc = 0, acc = 0;
  int en_cyc, b, a0;

  axis_video_pattern_gen dut (
    .i_axi_clk(clk), .i_axi_rst(rst_n), .i_enable(en), .i_width(w), .i_height(h),
    .i_frame_interval(ivl), .i_pattern(pat), .i_color(color), .i_clear_stats(clr),
    .o_busy(busy), .o_frame_count(fcount), .o_frame_late(late),
    .o_axis_out_tuser(tuser), .o_axis_out_tvalid(tvalid), .i_axis_out_tready(ready),
    .o_axis_out_tlast(tlast), .o_axis_out_tdata(tdata)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_frame(int fw, int fh, logic [1:0] p, logic [23:0] c);
    beat_t bt;
    for (int yy = 0; yy < fh; yy++)
      for (int xx = 0; xx < fw; xx++) begin
        bt.d = p == 2'd0 ? c : p == 2'd1 ? 24'(xx) : p == 2'd2 ? 24'(yy) :
               ((xx[3] ^ yy[3]) ? 24'hFFFFFF : 24'h0);
        bt.u = xx == 0 && yy == 0;
        bt.l = xx == fw - 1;
        q.push_back(bt);
      end
  endtask

  task automatic wait_sof(int n, int lim, string nm);
    int k = 0;
    while (sof_t.size() < n && k < lim) begin
      step();
      k++;
    end
    chk(nm, 32'(sof_t.size() >= n), 1);
  endtask

  task automatic wait_acc(int n, int lim, string nm);
    int k = 0;
    while (acc < n && k < lim) begin
      step();
      k++;
    end
    chk(nm, 32'(acc >= n), 1);
  endtask

  task automatic wait_done(int lim, string nm);
    int k = 0;
    while ((q.size() != 0 || busy) && k < lim) begin
      step();
      k++;
    end
    chk(nm, 32'(q.size() == 0 && !busy), 1);
  endtask

  // monitor: pops the scoreboard on every accepted beat and checks hold-stability during stalls
  initial begin
    logic stalled;
    logic [23:0] pd;
    logic pu, pl;
    beat_t e;
    stalled = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) stalled = 0;
      else begin
        if (stalled) begin
          chk("stall_valid", 32'(tvalid), 1);
          chk("stall_data", 32'(tdata), 32'(pd));
          chk("stall_user", 32'(tuser), 32'(pu));
          chk("stall_last", 32'(tlast), 32'(pl));
        end
        stalled = tvalid && !ready;
        pd = tdata;
        pu = tuser;
        pl = tlast;
        if (tvalid && ready) begin
          acc++;
          if (tuser) sof_t.push_back(cyc);
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %0h user %0b last %0b, expected no beat", tdata, tuser, tlast);
          end else begin
            e = q.pop_front();
            chk("beat_data", 32'(tdata), 32'(e.d));
            chk("beat_user", 32'(tuser), 32'(e.u));
            chk("beat_last", 32'(tlast), 32'(e.l));
          end
        end
      end
    end
  end

  initial begin
    #23 rst_n = 1;
    step();
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_count", fcount, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_late", 32'(late), 0);
    ready = 1;
    w = 4; h = 3; pat = 1; ivl = 100;
    push_frame(4, 3, 1, 0);
    push_frame(4, 3, 1, 0);
    step();
    en = 1;
    en_cyc = cyc;
    wait_sof(1, 50, "t2_first_sof");
    if (sof_t.size() > 0) chk("t2_latency", 32'(sof_t[0] - en_cyc), 2);
    wait_sof(2, 200, "t2_second_sof");
    chk("t2_count1", fcount, 1);
    en = 0;
    wait_done(100, "t2_done");
    chk("t2_count2", fcount, 2);
    if (sof_t.size() > 1) chk("t2_sof_gap", 32'(sof_t[1] - sof_t[0]), 100);
    pat = 2;
    push_frame(4, 3, 2, 0);
    a0 = acc;
    b = sof_t.size();
    rnd = 1;
    en = 1;
    wait_sof(b + 1, 300, "t3_sof");
    en = 0;
    wait_done(2000, "t3_done");
    rnd = 0;
    ready = 1;
    chk("t3_beats", 32'(acc - a0), 12);
    chk("t3_count", fcount, 3);
    w = 8; h = 8; pat = 1; ivl = 10;
    push_frame(8, 8, 1, 0);
    push_frame(8, 8, 1, 0);
    b = sof_t.size();
    step();
    en = 1;
    wait_sof(b + 1, 50, "t4_sof1");
    wait_sof(b + 2, 300, "t4_sof2");
    chk("t4_late", 32'(late), 1);
    chk("t4_count1", fcount, 4);
    en = 0;
    wait_done(200, "t4_done");
    chk("t4_count2", fcount, 5);
    if (sof_t.size() > b + 1) chk("t4_sof_gap", 32'(sof_t[b + 1] - sof_t[b]), 70);
    clr = 1;
    step();
    clr = 0;
    chk("t4_clr_count", fcount, 0);
    chk("t4_clr_late", 32'(late), 0);
    w = 4; h = 4; pat = 1; ivl = 100;
    push_frame(4, 4, 1, 0);
    a0 = acc;
    en = 1;
    wait_acc(a0 + 5, 200, "t5_beat5");
    en = 0;
    wait_done(200, "t5_done");
    repeat (30) step();
    chk("t5_beats", 32'(acc - a0), 16);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_tvalid", 32'(tvalid), 0);
    chk("t5_count", fcount, 1);
    w = 1; h = 1; pat = 0; color = 24'hABCDEF; ivl = 0;
    repeat (6) push_frame(1, 1, 0, 24'hABCDEF);
    b = sof_t.size();
    en = 1;
    wait_sof(b + 6, 100, "t6_sofs");
    en = 0;
    wait_done(50, "t6_done");
    for (int i = 1; i < 6; i++)
      if (sof_t.size() > b + i) chk("t6_gap", 32'(sof_t[b + i] - sof_t[b + i - 1]), 2);
    chk("t6_count", fcount, 7);
    chk("t6_late", 32'(late), 1);
    w = 0;
    en = 1;
    repeat (20) step();
    chk("t6_w0_busy", 32'(busy), 0);
    en = 0;
    step();
    chk("t6_w0_count", fcount, 7);
    w = 16; h = 9; pat = 3; ivl = 500;
    push_frame(16, 9, 3, 0);
    b = sof_t.size();
    en = 1;
    wait_sof(b + 1, 50, "t7_sof");
    en = 0;
    wait_done(400, "t7_done");
    chk("t7_count", fcount, 8);
    w = 4; h = 3; pat = 1; ivl = 100;
    push_frame(4, 3, 1, 0);
    a0 = acc;
    en = 1;
    wait_acc(a0 + 3, 200, "t8_beat3");
    #2 rst_n = 0;
    #1;
    chk("t8_tvalid", 32'(tvalid), 0);
    chk("t8_busy", 32'(busy), 0);
    chk("t8_tuser", 32'(tuser), 0);
    chk("t8_tlast", 32'(tlast), 0);
    chk("t8_tdata", 32'(tdata), 0);
    chk("t8_count", fcount, 0);
    chk("t8_late", 32'(late), 0);
    q.delete();
    en = 0;
    step();
    rst_n = 1;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_video_pattern_gen.md
Name: axis_video_pattern_gen

Overview:
AXI-Stream video source that emits complete frames. Frames start with tuser on the first pixel and end each line with tlast, and frames are paced by a programmable clock-cycle interval. It is the transmit-side counterpart of the team's stream frame/line/pixel monitor and feeds that monitor or downstream video IP for bring-up and rate testing. Configuration comes in on static ports, and statistics go out on status ports.

Parameters:
AXIS_DATA_WIDTH, 24, pixel width of tdata
IMG_WIDTH_MAX, 16, bit width of pixel-per-line count and x counter
IMG_HEIGHT_MAX, 16, bit width of lines-per-frame count and y counter

Ports:
i_axi_clk  input  1  sole clock
i_axi_rst  input  1  asynchronous active-low reset
i_enable  input  1  level; generate frames while high
i_width  input  IMG_WIDTH_MAX  pixels per line, sampled at frame start
i_height  input  IMG_HEIGHT_MAX  lines per frame, sampled at frame start
i_frame_interval  input  32  clocks between frame start ticks; 0 treated as 1
i_pattern  input  2  0 solid, 1 x-ramp, 2 y-ramp, 3 checker; sampled at frame start
i_color  input  AXIS_DATA_WIDTH  solid-pattern value
i_clear_stats  input  1  single-cycle pulse; clears o_frame_count and o_frame_late
o_busy  output  1  high in ACTIVE state
o_frame_count  output  32  frames completed (last beat accepted)
o_frame_late  output  1  sticky; an interval tick occurred while a frame was still ACTIVE
o_axis_out_tuser  output  1  start of frame, on pixel (0,0) only
o_axis_out_tvalid  output  1  beat valid
i_axis_out_tready  input  1  sink ready
o_axis_out_tlast  output  1  last pixel of each line
o_axis_out_tdata  output  AXIS_DATA_WIDTH  pixel data

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; interval counter, x, y, o_frame_count and o_frame_late cleared.
- Interval counter: runs only while i_enable=1. It counts 0..max(i_frame_interval,1)-1 and emits a one-cycle tick on wrap. It is forced to 0 in IDLE, so the first tick comes on the first enabled cycle after IDLE.
- FSM states are IDLE, WAIT, ACTIVE.
  - IDLE -> WAIT when i_enable=1.
  - WAIT -> ACTIVE on tick, if i_width!=0 and i_height!=0. The block latches width, height and pattern, and sets x=0, y=0. If either dimension is 0, the tick is ignored and the block stays in WAIT.
  - WAIT -> IDLE when i_enable=0.
  - ACTIVE -> WAIT (or IDLE if i_enable=0) when the final beat (x=w-1, y=h-1) is accepted.
- Latency: tick in cycle N -> o_axis_out_tvalid=1 with tuser=1 in cycle N+1. tvalid stays high through the whole ACTIVE state (no bubbles inserted by the block).
- Handshake: a beat is accepted when tvalid & tready. While tvalid=1 and tready=0, tdata/tuser/tlast hold stable. On accept: x++; at x=w-1, x->0 and y++.
- tuser=1 only for x=0,y=0. tlast=1 when x=w-1.
- Pixel data (x, y zero-extended or truncated to AXIS_DATA_WIDTH):
  - 0: i_color, latched at frame start.
  - 1: x.
  - 2: y.
  - 3: all ones if x[3]^y[3], else 0.
- i_enable dropped mid-frame: the current frame completes fully, then the block goes to IDLE. No truncated frames, ever.
- Config changes mid-frame have no effect until the next frame start.
- Tick while ACTIVE: no new frame is started and o_frame_late is set. The tick is dropped, not queued.
- o_frame_count: +1 on the final-beat accept, wraps at 2^32.
- i_clear_stats in the same cycle as an increment or a late event: clear wins, giving 0.
- Width 1: every beat has tlast=1.
- Width 1 and height 1: a single beat with both tuser and tlast set.

Test Plan:
1. Reset with all inputs 0, then release -> tvalid=0, o_frame_count=0, o_busy=0. Assert reset mid-frame -> outputs drop to 0 immediately (asynchronously).
2. w=4, h=3, pattern 1, interval=100, tready=1 -> first tvalid 1 cycle after tick with tuser=1. Data over 12 beats is 0,1,2,3 repeated; tlast on beats 4, 8, 12. o_frame_count=1; next tuser exactly 100 cycles after the first.
3. Same config, tready toggled 1/0 randomly -> tdata/tlast/tuser stable during stalls, 12 accepted beats total, pattern 2 gives y values 0,0,0,0,1,1,1,1,2,2,2,2.
4. w=8, h=8, interval=10 with tready=1 -> the frame takes 64 cycles. o_frame_late=1, the next frame starts at the first tick after completion, and o_frame_count increments once per frame. A single i_clear_stats pulse -> both cleared.
5. i_enable deasserted at beat 5 of a w=4, h=4 frame -> all 16 beats are still sent, then o_busy=0 and no further tvalid.
6. w=1, h=1, pattern 0, i_color=24'hABCDEF, interval=0 -> back-to-back single beats each carrying tuser=1, tlast=1 and tdata=ABCDEF. Setting w=0 -> no output while i_enable stays high.
